// File: rtl/shifter.sv
// rtl/shifter.sv - 32-bit registered barrel shifter (pass, SLL, SRA, SRL)
module shifter (
   input  logic        clk,
   input  logic        reset,
   output logic [31:0] out,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic        ctl0,
   input  logic        ctl1
);

   logic [1:0]  op;
   logic [4:0]  amt;
   logic        right;
   logic        fill;
   logic [31:0] rev_a;
   logic [31:0] st0;
   logic [31:0] st1;
   logic [31:0] st2;
   logic [31:0] st3;
   logic [31:0] st4;
   logic [31:0] shifted;
   logic [31:0] rev_out;
   logic [31:0] result;
   logic        unused_b_hi;

   assign op          = {ctl1, ctl0};
   assign amt         = B[4:0];
   assign unused_b_hi = ^B[31:5];

   // Right shifts reuse the left shifter on a bit-reversed operand; only SRA fills with the sign.
   assign right = ctl1;
   assign fill  = (op == 2'b10) ? A[31] : 1'b0;

   // Bit-reverse the operand for right shifts.
   always_comb begin
      rev_a = '0;
      for (int i = 0; i < 32; i++) begin
         rev_a[i] = A[31 - i];
      end
   end

   // Five cascaded left-shift stages by 1, 2, 4, 8 and 16, each enabled by one amount bit.
   always_comb begin
      st0     = right ? rev_a : A;
      st1     = amt[0] ? {st0[30:0], fill}          : st0;
      st2     = amt[1] ? {st1[29:0], {2{fill}}}     : st1;
      st3     = amt[2] ? {st2[27:0], {4{fill}}}     : st2;
      st4     = amt[3] ? {st3[23:0], {8{fill}}}     : st3;
      shifted = amt[4] ? {st4[15:0], {16{fill}}}    : st4;
   end

   // Undo the reversal for right shifts and pick the final result.
   always_comb begin
      rev_out = '0;
      for (int i = 0; i < 32; i++) begin
         rev_out[i] = shifted[31 - i];
      end
      result = A;
      if (op != 2'b00) begin
         result = right ? rev_out : shifted;
      end
   end

   // Output register; asynchronous reset clears it immediately.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         out <= '0;
      end else begin
         out <= result;
      end
   end

endmodule

// File: tb/tb_shifter.sv
// tb/tb_shifter.sv - directed self-checking bench for shifter
module tb_shifter;

   logic        clk;
   logic        reset;
   logic [31:0] out;
   logic [31:0] A;
   logic [31:0] B;
   logic        ctl0;
   logic        ctl1;

   int n_checks;
   int n_pass;

   shifter dut (
      .clk   (clk),
      .reset (reset),
      .out   (out),
      .A     (A),
      .B     (B),
      .ctl0  (ctl0),
      .ctl1  (ctl1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
      A    = a;
      B    = b;
      ctl1 = op[1];
      ctl0 = op[0];
   endtask

   task automatic run(input string tag, input logic [31:0] a, input logic [31:0] b,
                      input logic [1:0] op, input logic [31:0] exp);
      drive(a, b, op);
      @(posedge clk);
      #1;
      check(tag, out, exp);
   endtask

   function automatic logic [31:0] ref_model(input logic [31:0] a, input logic [4:0] n,
                                             input logic [1:0] op);
      logic [31:0] r;
      case (op)
         2'b00:   r = a;
         2'b01:   r = a << n;
         2'b10:   r = 32'($signed(a) >>> n);
         default: r = a >> n;
      endcase
      return r;
   endfunction

   typedef struct {
      string       tag;
      logic [31:0] a;
      logic [31:0] b;
      logic [1:0]  op;
      logic [31:0] exp;
   } vec_t;

   vec_t vecs[$];

   initial begin
      n_checks = 0;
      n_pass   = 0;
      reset    = 1'b1;
      drive(32'hDEAD_BEEF, 32'h0000_0003, 2'b01);

      // reset before any clock edge, then held across an edge
      #2;
      check("reset_no_edge", out, 32'h0);
      @(posedge clk);
      #1;
      check("reset_held_edge", out, 32'h0);
      reset = 1'b0;
      run("release_first", 32'h0000_0001, 32'd1, 2'b01, 32'h0000_0002);

      // async reset mid-stream discards the pending result
      drive(32'h0000_0001, 32'd7, 2'b01);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("reset_async_mid", out, 32'h0);
      @(posedge clk);
      #1;
      check("reset_discard", out, 32'h0);
      reset = 1'b0;

      vecs = '{
         '{"sll_31",    32'h0000_0001, 32'd31, 2'b01, 32'h8000_0000},
         '{"sll_7",     32'h0000_0001, 32'd7,  2'b01, 32'h0000_0080},
         '{"sll_1",     32'h0000_0001, 32'd1,  2'b01, 32'h0000_0002},
         '{"sll_0",     32'h0000_0001, 32'd0,  2'b01, 32'h0000_0001},
         '{"sra_31",    32'h8000_0000, 32'd31, 2'b10, 32'hFFFF_FFFF},
         '{"sra_7",     32'h8000_0000, 32'd7,  2'b10, 32'hFF00_0000},
         '{"sra_1",     32'h8000_0000, 32'd1,  2'b10, 32'hC000_0000},
         '{"sra_pos_7", 32'h7FFF_FFFF, 32'd7,  2'b10, 32'h00FF_FFFF},
         '{"srl_31",    32'hFFFF_FFFE, 32'd31, 2'b11, 32'h0000_0001},
         '{"srl_7",     32'hFFFF_FFFE, 32'd7,  2'b11, 32'h01FF_FFFF},
         '{"srl_1",     32'hFEFF_FFFF, 32'd1,  2'b11, 32'h7F7F_FFFF},
         '{"sll_b24_7", 32'h0100_0000, 32'd7,  2'b01, 32'h8000_0000},
         '{"pass_b5",   32'h1234_5678, 32'd5,  2'b00, 32'h1234_5678},
         '{"sll_bhi",   32'h0000_0001, 32'hFFFF_FFE1, 2'b01, 32'h0000_0002},
         '{"sra_bhi",   32'h8000_0000, 32'hFFFF_FFE1, 2'b10, 32'hC000_0000},
         '{"srl_bhi",   32'hFFFF_FFFE, 32'hFFFF_FFE1, 2'b11, 32'h7FFF_FFFF},
         '{"srl_0",     32'hA5A5_0F0F, 32'd0,  2'b11, 32'hA5A5_0F0F},
         '{"sra_0",     32'h8765_4321, 32'd0,  2'b10, 32'h8765_4321}
      };
      foreach (vecs[i]) begin
         run(vecs[i].tag, vecs[i].a, vecs[i].b, vecs[i].op, vecs[i].exp);
      end

      // single-bit sweep against the reference model
      for (int op = 0; op < 4; op++) begin
         for (int p = 0; p < 6; p++) begin
            for (int s = 0; s < 4; s++) begin
               logic [31:0] a;
               logic [4:0]  n;
               int          bitpos;
               bitpos = (p % 3 == 0) ? 0 : ((p % 3 == 1) ? 24 : 31);
               a      = 32'h1 << bitpos;
               if (p >= 3) a = ~a;
               n = (s == 0) ? 5'd0 : ((s == 1) ? 5'd1 : ((s == 2) ? 5'd7 : 5'd31));
               run($sformatf("sweep_op%0d_p%0d_n%0d", op, p, n), a, {27'd0, n}, op[1:0],
                   ref_model(a, n, op[1:0]));
            end
         end
      end

      // back-to-back: result appears exactly one cycle after its inputs
      drive(32'h0000_00F0, 32'd4, 2'b01);
      @(posedge clk);
      #1;
      check("b2b_first", out, 32'h0000_0F00);
      drive(32'hF000_0000, 32'd4, 2'b10);
      #1;
      check("b2b_hold", out, 32'h0000_0F00);
      @(posedge clk);
      #1;
      check("b2b_second", out, 32'hFF00_0000);
      drive(32'hF000_0000, 32'd4, 2'b11);
      @(posedge clk);
      #1;
      check("b2b_third", out, 32'h0F00_0000);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
